pipe_ctrl: RTL

Pipeline stall/flush controller for the 5-stage RV32 core; it is the control-side counterpart to the operand forwarding unit. Forwarding resolves every RAW hazard whose producer has data ready by MEM/WB/hold. This block handles the cases it cannot:
- load-use (load result not available until end of MEM),
- EX-stage redirects (taken branch/jump),
- data-memory wait states.

It drives the per-stage register enables and flushes, bounds memory waits with a timeout, and keeps a saturating stall-cycle counter.

---
 rtl/core_ctrl_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 35 +++
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_ctrl_pkg
//  Description : Shared control-side types and constants for the RV32 core
//                pipeline controller and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

  // Pipeline controller FSM states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  // Per-cycle pipeline action chosen by the controller
  typedef enum logic [1:0] {
    ACT_NORMAL   = 2'd0,
    ACT_FREEZE   = 2'd1,
    ACT_BUBBLE   = 2'd2,
    ACT_REDIRECT = 2'd3
  } pipe_act_e;

  // Hard-wired zero register; never a real dependency
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard term: a load in EX whose
//                destination is read by the instruction in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import core_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_rd_wr,
  input  logic       ex_is_load,
  output logic       load_use
);

  logic ex_load_wr;
  logic src_match;

  // Hazard exists only if a real (non-x0) load result is consumed by ID
  always_comb begin
    ex_load_wr = ex_valid & ex_rd_wr & ex_is_load & (ex_rd != REG_X0);
    src_match  = (id_rs1_used & (ex_rd == id_rs1_addr)) |
                 (id_rs2_used & (ex_rd == id_rs2_addr));
    load_use   = id_valid & ex_load_wr & src_match;
  end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline stall/flush controller for the 5-stage RV32 core.
//                Handles load-use bubbles, EX redirects and data-memory wait
//                states with a bounded timeout; counts stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_wr,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WC_W      = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  pipe_state_e      state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  pipe_act_e        act;
  pipe_act_e        run_act;
  logic             load_use;
  logic             mem_stall;
  logic             ack;
  logic             timeout;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_rd_wr    (ex_rd_wr),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  // Non-memory priority: a redirect squashes ID, so it beats load-use
  always_comb begin
    mem_stall = mem_req & ~mem_ack;
    ack       = mem_req & mem_ack;
    if (ex_redirect)   run_act = ACT_REDIRECT;
    else if (load_use) run_act = ACT_BUBBLE;
    else               run_act = ACT_NORMAL;
  end

  // FSM next state, wait counter and action selection
  always_comb begin
    act        = ACT_NORMAL;
    timeout    = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          act        = ACT_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          act = run_act;
        end
      end
      MEM_WAIT: begin
        if (ack) begin
          // Ack beats a coincident timeout
          act        = run_act;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Release with undefined load data; trap logic consumes mem_err
          timeout    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          act        = ACT_FREEZE;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Decode action into stage enables/flushes; reset forces a safe pattern
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_err     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      mem_err = timeout;
      case (act)
        ACT_FREEZE: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        ACT_REDIRECT: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        ACT_BUBBLE: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule : pipe_ctrl
`default_nettype wire
